// File: rtl/axi4_split_pkg.sv
// axi4_split_pkg: burst-type constants, FSM state and next-beat address helper for the read burst splitter
package axi4_split_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    // Computed at 64 bits; callers truncate to their address width, which gives modulo-2^ADDR_W wrap.
    // The reserved burst type falls through to the INCR arm.
    function automatic logic [63:0] next_addr(
        input logic [63:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst
    );
        logic [63:0] step;
        logic [63:0] mask;
        step = 64'd1 << size;
        mask = ((64'(len) + 64'd1) << size) - 64'd1;
        return burst == BURST_FIXED ? addr :
               burst == BURST_WRAP  ? (addr & ~mask) | ((addr + step) & mask) :
                                      addr + step;
    endfunction

endpackage

// File: rtl/axi4_rd_burst_splitter_if.sv
// axi4_rd_burst_splitter_if: upstream burst read channel and downstream single-beat read channel
interface axi4_rd_burst_splitter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 12
);
    logic              s_ar_valid;
    logic              s_ar_ready;
    logic [ADDR_W-1:0] s_ar_addr;
    logic [ID_W-1:0]   s_ar_id;
    logic [7:0]        s_ar_len;
    logic [2:0]        s_ar_size;
    logic [1:0]        s_ar_burst;
    logic              s_r_valid;
    logic              s_r_ready;
    logic [DATA_W-1:0] s_r_data;
    logic [ID_W-1:0]   s_r_id;
    logic              s_r_last;
    logic [1:0]        s_r_resp;
    logic              m_ar_valid;
    logic              m_ar_ready;
    logic [ADDR_W-1:0] m_ar_addr;
    logic [2:0]        m_ar_size;
    logic              m_r_valid;
    logic              m_r_ready;
    logic [DATA_W-1:0] m_r_data;
    logic [1:0]        m_r_resp;

    modport slave (
        input  s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_resp,
        output s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_last, s_r_resp,
        output m_ar_valid, m_ar_addr, m_ar_size, m_r_ready
    );

    modport master (
        output s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_resp,
        input  s_ar_ready, s_r_valid, s_r_data, s_r_id, s_r_last, s_r_resp,
        input  m_ar_valid, m_ar_addr, m_ar_size, m_r_ready
    );

endinterface

// File: rtl/axi4_rd_burst_splitter.sv
// axi4_rd_burst_splitter: turns one AXI4 read burst into a sequence of single-beat downstream reads
module axi4_rd_burst_splitter
    import axi4_split_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 12
) (
    input logic clk,
    input logic reset,
    axi4_rd_burst_splitter_if.slave bus
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_cnt;
    logic              r_s_ar_ready;
    logic              r_m_ar_valid;
    logic              w_wait;
    logic              w_last;
    logic              w_beat;
    logic [ADDR_W-1:0] w_next;
    logic [DATA_W-1:0] w_r_data;

    assign w_wait   = r_state == S_WAIT;
    assign w_last   = r_cnt == r_len;
    assign w_beat   = w_wait && bus.m_r_valid && bus.s_r_ready;
    assign w_next   = ADDR_W'(next_addr(64'(r_addr), r_len, r_size, r_burst));
    assign w_r_data = bus.m_r_data;

    assign bus.s_ar_ready = r_s_ar_ready;
    assign bus.m_ar_valid = r_m_ar_valid;
    assign bus.m_ar_addr  = r_addr;
    assign bus.m_ar_size  = r_size;
    assign bus.s_r_valid  = w_wait && bus.m_r_valid;
    assign bus.m_r_ready  = w_wait && bus.s_r_ready;
    assign bus.s_r_data   = w_r_data;
    assign bus.s_r_resp   = bus.m_r_resp;
    assign bus.s_r_id     = r_id;
    assign bus.s_r_last   = w_wait && w_last;

    // Burst sequencer: accept a burst, then alternate request/response once per beat
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_id         <= '0;
            r_len        <= '0;
            r_size       <= '0;
            r_burst      <= '0;
            r_cnt        <= '0;
            r_s_ar_ready <= 1'b1;
            r_m_ar_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.s_ar_valid) begin
                    r_addr       <= bus.s_ar_addr;
                    r_id         <= bus.s_ar_id;
                    r_len        <= bus.s_ar_len;
                    r_size       <= bus.s_ar_size;
                    r_burst      <= bus.s_ar_burst;
                    r_cnt        <= '0;
                    r_s_ar_ready <= 1'b0;
                    r_m_ar_valid <= 1'b1;
                    r_state      <= S_ISSUE;
                end
                S_ISSUE: if (bus.m_ar_ready) begin
                    r_m_ar_valid <= 1'b0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: if (w_beat) begin
                    if (w_last) begin
                        r_s_ar_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt        <= r_cnt + 8'd1;
                        r_addr       <= w_next;
                        r_m_ar_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
